float_div_sched: RTL
====================

Name: float_div_sched

Overview:
Shares one pipelined Newton-Raphson float divider (fixed latency, no stall) among NUM_REQ requesters.
- Arbitrates round-robin and issues at most one divide per cycle.
- Carries each issued operation's requester id and special-case result through a tag pipeline that matches the divider latency.
- Returns each quotient to the requester that issued it.
- Short-circuits zero operands, which the divider mishandles, so callers always receive IEEE-754 single-precision results.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 32, operand width; special-case encoding is defined for 32 only
DIV_LATENCY, 5, posedge cycles from div_a/div_b update to valid div_c; set at integration to the divider's measured latency

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  reset, asynchronous, active-low
flush  in  1  synchronous; kills all in-flight operations
req_valid  in  NUM_REQ  per-requester request
req_ready  out  NUM_REQ  one-hot grant; handshake when valid&ready
req_a  in  NUM_REQ*DATA_WIDTH  dividends, requester i at slice i
req_b  in  NUM_REQ*DATA_WIDTH  divisors, requester i at slice i
resp_valid  out  NUM_REQ  one-cycle result pulse to the owning requester
resp_data  out  DATA_WIDTH  quotient, shared by all requesters
resp_dz  out  1  divide-by-zero flag, qualified by any resp_valid
div_a  out  DATA_WIDTH  divider dividend input
div_b  out  DATA_WIDTH  divider divisor input
div_c  in  DATA_WIDTH  divider quotient output
busy  out  1  at least one operation in flight

Behaviour:
Reset (rst_n=0, asynchronous):
- All tag-pipe valid bits clear.
- Round-robin pointer = 0.
- div_a, div_b, resp_data = 0; resp_valid = 0; resp_dz = 0; busy = 0.

Arbitration (combinational):
- Grant the first requester with req_valid=1, searching from the pointer upward with wrap-around.
- req_ready is the one-hot grant and depends on req_valid.
- No valid requests gives req_ready=0.
- flush=1 forces req_ready=0.
- After a handshake, pointer <= granted id+1, mod NUM_REQ. Without a handshake the pointer holds.

Issue (handshake at edge k):
- div_a/div_b <= operands of the granted requester.
- On an idle cycle div_a/div_b <= 0 (bubble).
- Tag stage 0 <= {valid=1, id, spec, spec_val, dz}.

Special classification (exponent field [30:23], sign [31]):
- B exponent==0 (zero or denormal): spec=1, dz=1, spec_val = {sA^sB, 8'hFF, 23'h0}. This rule takes priority when both A and B are zero.
- Otherwise, A exponent==0: spec=1, dz=0, spec_val = {sA^sB, 31'h0}.
- Otherwise: spec=0, dz=0.
- Special operations still occupy a pipeline slot, which preserves ordering.

Tag pipeline:
- DIV_LATENCY stages, shifting every cycle unconditionally.
- The last stage aligns with div_c for the same operation.

Response (registered, edge k+DIV_LATENCY+1):
- resp_valid[id]=1 for exactly one cycle.
- resp_data = spec ? spec_val : div_c.
- resp_dz = dz.
- Otherwise resp_valid=0, and resp_data/resp_dz hold their last value.
- There is no backpressure: requesters must accept on the pulse.

Throughput and ordering:
- One issue per cycle sustained.
- Responses come back in issue order.
- A single requester may have up to DIV_LATENCY operations outstanding.

busy = OR of all tag-stage valids and the response-register valid.

flush=1 at edge k:
- All tag valids clear, and no responses pulse from edge k+1 onward for operations issued before k.
- No new grant is made in that cycle.
- The pointer holds.

Reset mid-operation: everything in flight is discarded; no resp_valid after rst_n deasserts until new issues complete.

Simultaneous issue and completion in the same cycle is normal operation: both happen independently.

Decomposition:
Package float_div_pkg holds:
- DATA_WIDTH default, EXP_MSB=30, EXP_LSB=23, SIGN_BIT=31.
- FP_INF_MAG=31'h7F800000.
- Tag typedef {valid, id[$clog2(NUM_REQ)], spec, spec_val, dz}.
- classify function returning spec/dz/spec_val.

Sub-module float_div_rr_arb holds the round-robin pointer and grant logic.

Test Plan:
- Single requester 0: A=0x40C00000 (6.0), B=0x40000000 (2.0) -> resp_valid[0] pulses exactly DIV_LATENCY+1 edges after handshake; resp_data within 2 ulp of 0x40400000; resp_dz=0.
- All 4 requesters valid continuously with distinct operands -> grants 0,1,2,3,0,... one per cycle; responses arrive in the same order with matching ids; busy stays 1 until the last pulse.
- B=0x00000000, A=0xBF800000 (-1.0) -> resp_data=0xFF800000, resp_dz=1. A=0x80000000, B=0x40000000 -> resp_data=0x80000000, resp_dz=0. A=0, B=0 -> 0x7F800000, resp_dz=1.
- Pointer at 2, only requesters 0 and 3 valid -> grant 3 first, then 0; the pointer wraps correctly.
- Issue 3 ops, assert flush two cycles later -> no resp_valid for those ops; busy=0 one edge after flush; next request completes normally.
- Assert rst_n=0 with 4 ops in flight -> all outputs 0 immediately (asynchronously); after release, no stale resp_valid for DIV_LATENCY+2 cycles.

Source files
------------

// File: rtl/float_div_pkg.sv
// Shared constants, tag layout and IEEE-754 single-precision special-case
// classification used by the float divider scheduler.
package float_div_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int SIGN_BIT       = 31;
  localparam int EXP_MSB        = 30;
  localparam int EXP_LSB        = 23;
  localparam logic [30:0] FP_INF_MAG = 31'h7F800000;

  // Id field sized for the largest supported requester count (8).
  localparam int TAG_ID_W = 3;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
    logic                spec;
    logic [31:0]         spec_val;
    logic                dz;
  } tag_t;

  typedef struct packed {
    logic        spec;
    logic        dz;
    logic [31:0] spec_val;
  } class_t;

  // Inputs are {sign, exponent}; a zero exponent covers zero and denormals,
  // and a zero/denormal divisor wins over a zero/denormal dividend.
  function automatic class_t classify(input logic [8:0] a_se, input logic [8:0] b_se);
    class_t c;
    logic   sgn;
    sgn = a_se[8] ^ b_se[8];
    c   = '0;
    if (b_se[7:0] == 8'h00) begin
      c.spec     = 1'b1;
      c.dz       = 1'b1;
      c.spec_val = {sgn, FP_INF_MAG};
    end else if (a_se[7:0] == 8'h00) begin
      c.spec     = 1'b1;
      c.spec_val = {sgn, 31'h0};
    end
    return c;
  endfunction

endpackage

// File: rtl/float_div_sched_if.sv
// Requester-side and divider-side signals of the shared divider scheduler.
interface float_div_sched_if
  import float_div_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic                          flush;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]            resp_valid;
  logic [DATA_WIDTH-1:0]         resp_data;
  logic                          resp_dz;
  logic [DATA_WIDTH-1:0]         div_a;
  logic [DATA_WIDTH-1:0]         div_b;
  logic [DATA_WIDTH-1:0]         div_c;
  logic                          busy;

  modport slave (
    input  flush, req_valid, req_a, req_b, div_c,
    output req_ready, resp_valid, resp_data, resp_dz, div_a, div_b, busy
  );

  modport master (
    output flush, req_valid, req_a, req_b, div_c,
    input  req_ready, resp_valid, resp_data, resp_dz, div_a, div_b, busy
  );
endinterface

// File: rtl/float_div_rr_arb.sv
// Round-robin arbiter: searches upward from the pointer with wrap-around and
// advances the pointer past the winner on each grant.
module float_div_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic [NUM_REQ-1:0] req_valid_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    grant_id_o,
  output logic               grant_vld_o
);

  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] ptr_d;
  logic [ID_W-1:0] gid;
  logic            gvld;
  int              idx;

  always_comb begin
    gid  = '0;
    gvld = 1'b0;
    idx  = 0;
    if (!flush_i) begin
      for (int off = 0; off < NUM_REQ; off++) begin
        idx = int'(ptr_q) + off;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!gvld && req_valid_i[ID_W'(idx)]) begin
          gvld = 1'b1;
          gid  = ID_W'(idx);
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gvld) ptr_d = (gid == ID_W'(NUM_REQ - 1)) ? '0 : gid + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign grant_o     = gvld ? (NUM_REQ'(1) << gid) : '0;
  assign grant_id_o  = gid;
  assign grant_vld_o = gvld;

endmodule

// File: rtl/float_div_sched.sv
// Shares one fixed-latency pipelined float divider among NUM_REQ requesters,
// tagging each issue so its quotient (or special-case result) returns to its owner.
module float_div_sched
  import float_div_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int DIV_LATENCY = 5
) (
  input logic              clk,
  input logic              rst_n,
  float_div_sched_if.slave bus
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               grant_vld;

  float_div_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (bus.flush),
    .req_valid_i (bus.req_valid),
    .grant_o     (grant),
    .grant_id_o  (grant_id),
    .grant_vld_o (grant_vld)
  );

  assign bus.req_ready = grant;

  logic [DATA_WIDTH-1:0] a_slice [NUM_REQ];
  logic [DATA_WIDTH-1:0] b_slice [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign a_slice[gi] = bus.req_a[gi*DATA_WIDTH +: DATA_WIDTH];
    assign b_slice[gi] = bus.req_b[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  logic [DATA_WIDTH-1:0] sel_a;
  logic [DATA_WIDTH-1:0] sel_b;
  logic [DATA_WIDTH-1:0] div_a_d, div_a_q;
  logic [DATA_WIDTH-1:0] div_b_d, div_b_q;
  class_t                cls;
  tag_t                  tag0_d;

  assign sel_a = a_slice[grant_id];
  assign sel_b = b_slice[grant_id];

  always_comb begin
    cls     = classify({sel_a[SIGN_BIT], sel_a[EXP_MSB:EXP_LSB]},
                       {sel_b[SIGN_BIT], sel_b[EXP_MSB:EXP_LSB]});
    div_a_d = '0;
    div_b_d = '0;
    tag0_d  = '0;
    if (grant_vld) begin
      div_a_d         = sel_a;
      div_b_d         = sel_b;
      tag0_d.valid    = 1'b1;
      tag0_d.id       = TAG_ID_W'(grant_id);
      tag0_d.spec     = cls.spec;
      tag0_d.spec_val = cls.spec_val;
      tag0_d.dz       = cls.dz;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_a_q <= '0;
      div_b_q <= '0;
    end else begin
      div_a_q <= div_a_d;
      div_b_q <= div_b_d;
    end
  end

  // tag_q[0] is captured alongside div_a/div_b; div_c for that operation
  // appears DIV_LATENCY edges later, which is when it reaches tag_q[DIV_LATENCY].
  tag_t tag_q [DIV_LATENCY+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= DIV_LATENCY; i++) tag_q[i] <= '0;
    end else if (bus.flush) begin
      for (int i = 0; i <= DIV_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag0_d;
      for (int i = 1; i <= DIV_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  tag_t                  last;
  logic [NUM_REQ-1:0]    resp_valid_d, resp_valid_q;
  logic [DATA_WIDTH-1:0] resp_data_d,  resp_data_q;
  logic                  resp_dz_d,    resp_dz_q;

  assign last = tag_q[DIV_LATENCY];

  always_comb begin
    resp_valid_d = '0;
    resp_data_d  = resp_data_q;
    resp_dz_d    = resp_dz_q;
    if (last.valid && !bus.flush) begin
      resp_valid_d = NUM_REQ'(1) << last.id;
      resp_data_d  = last.spec ? last.spec_val : bus.div_c;
      resp_dz_d    = last.dz;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      resp_dz_q    <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_dz_q    <= resp_dz_d;
    end
  end

  logic busy;
  always_comb begin
    busy = |resp_valid_q;
    for (int i = 0; i <= DIV_LATENCY; i++) busy = busy | tag_q[i].valid;
  end

  assign bus.div_a      = div_a_q;
  assign bus.div_b      = div_b_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_dz    = resp_dz_q;
  assign bus.busy       = busy;

endmodule
